// File: rtl/mic_axil_regs_if.sv
// AXI4-Lite slave bus bundle for the microphone register block.
// Signal names follow the AXI naming the interconnect side expects.
interface mic_axil_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/mic_axil_regs.sv
// AXI4-Lite register file for the PDM microphone: CTRL, CLKDIV, two scratch
// words, plus the mic clock divider and the PDM bit capture it controls.
//
// Write channel FSM:
//   state  | meaning
//   W_IDLE | no write outstanding, waiting for AWVALID and WVALID together
//   W_ACK  | AWREADY/WREADY pulse; register commits on this cycle's edge
//   W_RESP | BVALID held until BREADY
module mic_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    mic_axil_regs_if.slave   s_axi,
    output logic             mic_clk,
    output logic             mic_lr,
    input  logic             mic_data,
    output logic             pdm_bit,
    output logic             pdm_valid
);
    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_t;

    wstate_t                        wstate, wstate_nxt;
    logic                           awready, wready, bvalid;
    logic                           arready, rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0]  regs [4];
    logic                           wr_fire;
    logic [1:0]                     widx, ridx;
    logic [7:0]                     cnt;
    logic [7:0]                     div;
    logic                           en, tc;
    logic                           unused_bits;

    assign widx = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ridx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) wstate <= W_IDLE;
        else          wstate <= wstate_nxt;
    end

    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE: if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) wstate_nxt = W_ACK;
            // a master that drops VALID during the ready pulse gets no response
            W_ACK:  wstate_nxt = (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) ? W_RESP : W_IDLE;
            W_RESP: if (s_axi.S_AXI_BREADY) wstate_nxt = W_IDLE;
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wstate)
            W_ACK:   begin awready = 1'b1; wready = 1'b1; end
            W_RESP:  bvalid = 1'b1;
            default: ;
        endcase
    end

    assign wr_fire = (wstate == W_ACK) && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int r = 0; r < 4; r++) regs[r] <= '0;
        end else if (wr_fire) begin
            for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
                if (s_axi.S_AXI_WSTRB[b]) regs[widx][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
        end
    end

    // RDATA is sampled on the same edge a write commits, so it sees the old value
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            arready <= s_axi.S_AXI_ARVALID && !arready && !rvalid;
            if (arready && s_axi.S_AXI_ARVALID) begin
                rvalid <= 1'b1;
                rdata  <= regs[ridx];
            end else if (rvalid && s_axi.S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RDATA   = rdata;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    assign en     = regs[0][0];
    assign mic_lr = regs[0][1];
    assign div    = regs[1][7:0];
    // live compare: a CLKDIV below the count lets the 8-bit counter roll past 0xFF
    assign tc     = (cnt == div);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt     <= '0;
            mic_clk <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            mic_clk <= 1'b0;
        end else if (tc) begin
            cnt     <= '0;
            mic_clk <= ~mic_clk;
        end else begin
            cnt     <= cnt + 8'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pdm_bit   <= 1'b0;
            pdm_valid <= 1'b0;
        end else begin
            pdm_valid <= en && tc && !mic_clk;
            if (en && tc && !mic_clk) pdm_bit <= mic_data;
        end
    end

    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                           regs[0][31:2], regs[1][31:8]};
endmodule

// File: tb/tb_mic_axil_regs.sv
// Directed bench for mic_axil_regs: AXI-Lite access, byte strobes, back-pressure,
// same-edge read/write, mic clock divider, PDM capture and mid-transaction reset.
module tb_mic_axil_regs;
    logic clk = 1'b0;
    logic rst_n;
    logic mic_clk, mic_lr, mic_data, pdm_bit, pdm_valid;
    int   total = 0;
    int   bad   = 0;

    mic_axil_regs_if bus ();

    mic_axil_regs dut (
        .ACLK      (clk),
        .ARESETN   (rst_n),
        .s_axi     (bus),
        .mic_clk   (mic_clk),
        .mic_lr    (mic_lr),
        .mic_data  (mic_data),
        .pdm_bit   (pdm_bit),
        .pdm_valid (pdm_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, output int lat);
        int n;
        @(negedge clk);
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        n = 0;
        while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
        lat = n;
        chk("wr_wready", {31'b0, bus.S_AXI_WREADY}, 32'd1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
        chk("wr_bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd1);
        chk("wr_bresp", {30'b0, bus.S_AXI_BRESP}, 32'd0);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output int lat);
        int n;
        @(negedge clk);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        n = 0;
        while (!bus.S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
        lat = n;
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
        chk("rd_rvalid", {31'b0, bus.S_AXI_RVALID}, 32'd1);
        chk("rd_rresp", {30'b0, bus.S_AXI_RRESP}, 32'd0);
        d = bus.S_AXI_RDATA;
        @(negedge clk);
    endtask

    function automatic logic [31:0] out_vec();
        return {23'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                bus.S_AXI_ARREADY, bus.S_AXI_RVALID, mic_clk, mic_lr, pdm_bit, pdm_valid};
    endfunction

    initial begin
        logic [31:0] d;
        logic [31:0] wvals [4];
        int lat, n, errs, cnt;
        logic prev;

        wvals[0] = 32'h1; wvals[1] = 32'h2; wvals[2] = 32'h3; wvals[3] = 32'h4;
        rst_n = 1'b0;
        mic_data = 1'b0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        #23;
        chk("rst_outs", out_vec(), 32'd0);
        chk("rst_rdata", bus.S_AXI_RDATA, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic write/readback with latency on the first access
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), wvals[i], 4'hF, lat);
            if (i == 0) chk("wr_latency", lat, 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, lat);
            if (i == 0) chk("rd_latency", lat, 32'd1);
            chk("readback", d, wvals[i]);
        end

        // byte strobes
        axi_write(4'h8, 32'hAABBCCDD, 4'hF, lat);
        axi_write(4'h8, 32'h11223344, 4'b0101, lat);
        axi_read(4'h8, d, lat);
        chk("wstrb_merge", d, 32'hAA22CC44);

        // BREADY back-pressure blocks a second write
        @(negedge clk);
        bus.S_AXI_AWADDR = 4'h8; bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
        n = 0;
        while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_WDATA = 32'h4;
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            if (!bus.S_AXI_BVALID || bus.S_AXI_AWREADY) errs++;
        end
        chk("bready_hold", errs, 32'd0);
        bus.S_AXI_BREADY = 1'b1;
        n = 0;
        while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
        chk("second_aw", {31'b0, bus.S_AXI_AWREADY}, 32'd1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        chk("second_b", {31'b0, bus.S_AXI_BVALID}, 32'd1);
        @(negedge clk);
        axi_read(4'h8, d, lat);
        chk("bp_first", d, 32'h12345678);
        axi_read(4'hC, d, lat);
        chk("bp_second", d, 32'h4);

        // mic clock: N=3 gives period 8, high for 4
        axi_write(4'h4, 32'd3, 4'hF, lat);
        axi_write(4'h0, 32'd1, 4'hF, lat);
        mic_data = 1'b1;
        prev = mic_clk; n = 0;
        do begin prev = mic_clk; @(negedge clk); n++; end while (!(prev == 1'b0 && mic_clk == 1'b1) && n < 40);
        cnt = 0;
        while (mic_clk && cnt < 40) begin @(negedge clk); cnt++; end
        chk("mic_half", cnt, 32'd4);
        while (!mic_clk && cnt < 40) begin @(negedge clk); cnt++; end
        chk("mic_period", cnt, 32'd8);
        chk("pdm_bit_1", {31'b0, pdm_bit}, 32'd1);
        cnt = 0;
        repeat (64) begin @(negedge clk); if (pdm_valid) cnt++; end
        chk("pdm_pulses", cnt, 32'd8);
        mic_data = 1'b0;
        repeat (10) @(negedge clk);
        chk("pdm_bit_0", {31'b0, pdm_bit}, 32'd0);

        axi_write(4'h0, 32'd3, 4'hF, lat);
        chk("mic_lr_1", {31'b0, mic_lr}, 32'd1);
        axi_write(4'h0, 32'd0, 4'hF, lat);
        cnt = 0;
        repeat (20) begin @(negedge clk); if (mic_clk || pdm_valid) cnt++; end
        chk("disabled", cnt, 32'd0);
        chk("mic_lr_0", {31'b0, mic_lr}, 32'd0);

        // same-edge write and read to SCRATCH1
        @(negedge clk);
        bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = 4'hC; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
        n = 0;
        while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
        chk("same_edge_ar", {31'b0, bus.S_AXI_ARREADY}, 32'd1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        chk("same_edge_rv", {31'b0, bus.S_AXI_RVALID}, 32'd1);
        chk("same_edge_old", bus.S_AXI_RDATA, 32'h4);
        @(negedge clk);
        axi_read(4'hC, d, lat);
        chk("same_edge_new", d, 32'h55);

        // reset while RVALID pending and mic_clk running
        axi_write(4'h0, 32'd1, 4'hF, lat);
        @(negedge clk);
        bus.S_AXI_ARADDR = 4'h8; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
        n = 0;
        while (!bus.S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        repeat (3) @(negedge clk);
        chk("rv_hold", {31'b0, bus.S_AXI_RVALID}, 32'd1);
        chk("rv_data", bus.S_AXI_RDATA, 32'h12345678);
        n = 0;
        while (!mic_clk && n < 20) begin @(negedge clk); n++; end
        chk("mic_running", {31'b0, mic_clk}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outs", out_vec(), 32'd0);
        chk("midrst_rdata", bus.S_AXI_RDATA, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, lat);
            chk("post_rst_reg", d, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
